// File: rtl/eu_logic_if.sv
// Control-unit handshake and operand bus for the logic execution unit.
interface eu_logic_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 start;
    logic [3:0]           op_select;
    logic [BUS_WIDTH-1:0] A;
    logic [BUS_WIDTH-1:0] B;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] data_out;
    logic                 zero;
    logic                 carry;

    modport master (
        output start, op_select, A, B,
        input  busy, done, data_out, zero, carry
    );

    modport slave (
        input  start, op_select, A, B,
        output busy, done, data_out, zero, carry
    );
endinterface

// File: rtl/eu_logic_seq.sv
// Logic execution unit: single-cycle bitwise ops and
// bit-serial shift/rotate with start/busy/done handshake.
module eu_logic_seq #(
    parameter int BUS_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    eu_logic_if.slave  bus
);
    localparam int SHAMT_W = $clog2(BUS_WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 cint_q, cint_d;
    logic                 done_q, done_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;

    logic [BUS_WIDTH-1:0] logic_res;
    logic [BUS_WIDTH-1:0] step_acc;
    logic                 step_carry;

    always_comb begin
        logic_res = '0;
        unique case (bus.op_select[1:0])
            2'b00: logic_res = bus.A & bus.B;
            2'b01: logic_res = bus.A | bus.B;
            2'b10: logic_res = bus.A ^ bus.B;
            2'b11: logic_res = ~bus.A;
        endcase
    end

    // One bit position per cycle; carry is the bit leaving (or wrapping).
    always_comb begin
        step_acc   = acc_q;
        step_carry = 1'b0;
        unique case (op_q)
            2'b00: begin
                step_acc   = {acc_q[BUS_WIDTH-2:0], 1'b0};
                step_carry = acc_q[BUS_WIDTH-1];
            end
            2'b01: begin
                step_acc   = {1'b0, acc_q[BUS_WIDTH-1:1]};
                step_carry = acc_q[0];
            end
            2'b10: begin
                step_acc   = {acc_q[BUS_WIDTH-2:0], acc_q[BUS_WIDTH-1]};
                step_carry = acc_q[BUS_WIDTH-1];
            end
            2'b11: begin
                step_acc   = {acc_q[0], acc_q[BUS_WIDTH-1:1]};
                step_carry = acc_q[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cint_d  = cint_q;
        data_d  = data_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.op_select[3]) begin
                    if (!bus.op_select[2]) begin
                        data_d  = logic_res;
                        zero_d  = (logic_res == '0);
                        carry_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        acc_d   = bus.A;
                        cnt_d   = bus.B[SHAMT_W-1:0];
                        op_d    = bus.op_select[1:0];
                        cint_d  = 1'b0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d  = step_acc;
                    cint_d = step_carry;
                    cnt_d  = cnt_q - CNT_ONE;
                end else begin
                    data_d  = acc_q;
                    zero_d  = (acc_q == '0);
                    carry_d = cint_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            cint_q  <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cint_q  <= cint_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.data_out = data_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
endmodule

// File: tb/tb_eu_logic_seq.sv
// Directed scoreboard bench for eu_logic_seq (BUS_WIDTH=8).
module tb_eu_logic_seq;
    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic       c;
    } exp_t;

    logic clk;
    logic rst_n;
    eu_logic_if #(.BUS_WIDTH(8)) bus ();

    eu_logic_seq #(.BUS_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;
    int   busy_run = 0;
    int   last_busy = 0;
    int   lat = 0;
    int   d0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                exp_t e;
                done_seen++;
                last_busy = busy_run;
                busy_run  = 0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: data 0x%0h with empty queue",
                             bus.data_out);
                end else begin
                    e = q.pop_front();
                    chk("sb_data",  32'(bus.data_out), 32'(e.d));
                    chk("sb_zero",  32'(bus.zero),     32'(e.z));
                    chk("sb_carry", 32'(bus.carry),    32'(e.c));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit push,
                         input logic [7:0] ed, input logic ez,
                         input logic ec);
        exp_t e;
        bus.start     = 1'b1;
        bus.op_select = op;
        bus.A         = a;
        bus.B         = b;
        if (push) begin
            e.d = ed;
            e.z = ez;
            e.c = ec;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op_select = 4'b1011;
        bus.A         = ~a;
        bus.B         = ~b;
    endtask

    task automatic wait_done(input string name, input int max);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.done && c < max);
        if (!bus.done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done after %0d cycles, needed <= %0d",
                     name, c, max);
        end
        lat = c;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op_select = 4'b0000;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(bus.data_out), 32'h00);
        chk("rst_zero",  32'(bus.zero),     32'h1);
        chk("rst_carry", 32'(bus.carry),    32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_done",  32'(bus.done),     32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", {bus.data_out, bus.zero, bus.carry, bus.busy, bus.done},
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});

        issue(4'b1000, 8'hF0, 8'h3C, 1, 8'h30, 0, 0);
        wait_done("and", 4);
        chk("and_latency", lat, 1);
        issue(4'b1010, 8'h55, 8'h55, 1, 8'h00, 1, 0);
        wait_done("xor", 4);
        chk("xor_b2b_latency", lat, 1);

        issue(4'b1100, 8'h81, 8'h01, 1, 8'h02, 0, 1);
        wait_done("shl", 6);
        chk("shl_busy", last_busy, 2);
        issue(4'b1011, 8'h3C, 8'h00, 1, 8'hC3, 0, 0);
        wait_done("not", 4);
        issue(4'b1111, 8'h01, 8'hF1, 1, 8'h80, 0, 1);
        wait_done("ror", 6);
        issue(4'b1001, 8'h0F, 8'hA0, 1, 8'hAF, 0, 0);
        wait_done("or", 4);

        d0 = done_seen;
        issue(4'b1101, 8'h80, 8'h07, 1, 8'h01, 0, 0);
        repeat (3) @(negedge clk);
        chk("shr_hold", 32'(bus.data_out), 32'hAF);
        bus.start     = 1'b1;
        bus.op_select = 4'b1000;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("shr", 12);
        chk("shr_busy", last_busy, 8);
        repeat (3) @(negedge clk);
        chk("shr_done_once", done_seen - d0, 1);

        issue(4'b1110, 8'hA5, 8'h08, 1, 8'hA5, 0, 0);
        wait_done("rol_n0", 4);
        chk("rol_n0_busy", last_busy, 1);

        d0 = done_seen;
        bus.start     = 1'b1;
        bus.op_select = 4'b0011;
        bus.A         = 8'hFF;
        bus.B         = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("illegal_nodone", done_seen - d0, 0);
        chk("illegal_busy", 32'(bus.busy), 32'h0);
        chk("illegal_hold", {bus.data_out, bus.zero, bus.carry},
            {8'hA5, 1'b0, 1'b0});

        d0 = done_seen;
        issue(4'b1100, 8'hFF, 8'h05, 0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {bus.data_out, bus.zero, bus.carry, bus.busy},
            {8'h00, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_nodone", done_seen - d0, 0);
        issue(4'b1110, 8'h81, 8'h02, 1, 8'h06, 0, 0);
        wait_done("post_rst_rol", 8);
        chk("post_rst_busy", last_busy, 3);

        repeat (2) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
